figure_uart_transmit: RTL

UART transmitter for the Bluetooth serial link, driving the module's RX pin. It reports the four recognized digits back to the host as one ASCII frame per transmission: digits 1..4, then CR LF. It runs in the system `clk` domain beside the Bluetooth receiver. It takes the four 4-bit digit codes produced by the figure-recognition path, which originate in the camera pixel-clock domain.

---
 rtl/figure_uart_transmit_if.sv | 23 ++
 rtl/figure_uart_transmit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/figure_uart_transmit_if.sv
// Digit inputs, request controls and serial-line status shared between the
// figure-recognition host and the UART transmitter.
interface figure_uart_transmit_if;
  logic [3:0] num1;
  logic [3:0] num2;
  logic [3:0] num3;
  logic [3:0] num4;
  logic       send_req;
  logic       auto_en;
  logic       txd;
  logic       busy;
  logic       done;

  modport master (
    output num1, num2, num3, num4, send_req, auto_en,
    input  txd, busy, done
  );

  modport slave (
    input  num1, num2, num3, num4, send_req, auto_en,
    output txd, busy, done
  );
endinterface

// File: rtl/figure_uart_transmit.sv
// 8N1 UART transmitter: sends the four recognised digits as ASCII followed by
// CR LF, on request or automatically when the stable digit set changes.
module figure_uart_transmit #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic                         clk,
  input  logic                         reset,
  figure_uart_transmit_if.slave        bus_io
);

  localparam int unsigned CPB  = CLK_FREQ / BAUD;
  localparam int unsigned CntW = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CPB - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [2:0]      byte_q, byte_d;
  logic [15:0]     s1_q, s2_q;
  logic [15:0]     frame_q, frame_d;
  logic [15:0]     last_q, last_d;
  logic            txd_q, txd_d;
  logic            done_q, done_d;
  logic            stable, trig, bit_end;
  logic [7:0]      cur_byte;

  function automatic logic [7:0] to_ascii(input logic [3:0] v);
    return (v <= 4'd9) ? (8'h30 + {4'h0, v}) : 8'h3F;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [15:0] f, input logic [2:0] idx);
    case (idx)
      3'd0:    return to_ascii(f[15:12]);
      3'd1:    return to_ascii(f[11:8]);
      3'd2:    return to_ascii(f[7:4]);
      3'd3:    return to_ascii(f[3:0]);
      3'd4:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  // Two plain register stages; "stable" compares them, no further CDC handling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= {bus_io.num1, bus_io.num2, bus_io.num3, bus_io.num4};
      s2_q <= s1_q;
    end
  end

  assign stable   = (s1_q == s2_q);
  assign trig     = bus_io.send_req | (bus_io.auto_en & stable & (s2_q != last_q));
  assign bit_end  = (cnt_q == CntMax);
  assign cur_byte = frame_byte(frame_q, byte_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    frame_d = frame_q;
    last_d  = last_q;
    txd_d   = txd_q;
    done_d  = 1'b0;

    if (state_q != StIdle) begin
      cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
    end

    case (state_q)
      StIdle: begin
        txd_d = 1'b1;
        if (trig) begin
          state_d = StStart;
          txd_d   = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
          frame_d = s2_q;
          last_d  = s2_q;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = '0;
          txd_d   = cur_byte[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = StStop;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = cur_byte[bit_q + 3'd1];
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          if (byte_q == 3'd5) begin
            state_d = StIdle;
            txd_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = StStart;
            byte_d  = byte_q + 3'd1;
            txd_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      frame_q <= '0;
      last_q  <= 16'hFFFF;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      frame_q <= frame_d;
      last_q  <= last_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

  assign bus_io.txd  = txd_q;
  assign bus_io.busy = (state_q != StIdle);
  assign bus_io.done = done_q;

endmodule
